// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional feature macro: MIPS_CTRL_ADDI_EN builds the addi path (IEXEC -> IWB).
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_ir_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_iord,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic [3:0] o_state,
  output logic       o_illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_set_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal)
        r_illegal <= 1'b1;
    end
  end

  // Outputs are Moore except the FETCH handshake enables and the BRANCH zero gate.
  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    o_pc_write    = 1'b0;
    o_ir_write    = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_iord        = 1'b0;
    o_reg_dst     = 1'b0;
    o_mem_to_reg  = 1'b0;
    o_reg_write   = 1'b0;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'b00;
    o_alu_op      = 2'b00;
    o_pc_src      = 2'b00;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        if (i_mem_ready) begin
          o_pc_write = 1'b1;
          o_ir_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        case (i_opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      w_next = S_IEXEC;
`endif
          default: begin
            w_next        = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
        if (i_mem_ready)
          w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        if (i_mem_ready)
          w_next = S_FETCH;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b01;
        o_pc_src    = 2'b01;
        o_pc_write  = i_zero;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        o_pc_src   = 2'b10;
        o_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_IEXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_next      = S_IWB;
      end
      S_IWB: begin
        o_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  assign o_state      = r_state;
  assign o_illegal_op = r_illegal;

endmodule
